ahb_mem_slave: RTL

Parametrised AHB-Lite memory slave: the next generation of the mock peripheral that sits on the DMAC master bus in the top-level bench. It generalises depth, base address and data width, and adds:
- configurable and runtime-injected wait states;
- HSIZE/strobe-aware byte-lane writes;
- a two-cycle ERROR response for out-of-range, misaligned or injected faults.

DMAC source and destination instances use it for stall and error coverage.

---
 rtl/ahb_pkg.sv | 48 ++++
 rtl/ahb_mem_slave.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB-Lite encodings and the byte-lane mask helper used by
//             the memory slave and its benches.
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_t;

  localparam hresp_t OKAY  = HRESP_OKAY;
  localparam hresp_t ERROR = HRESP_ERROR;

  // Lanes touched by a transfer of 2^hsize bytes starting at lane addr_lsbs.
  // Sizes beyond a doubleword touch no lanes; callers flag them as errors.
  function automatic logic [7:0] size_mask(input logic [2:0] hsize,
                                           input logic [2:0] addr_lsbs);
    logic [15:0] ones;
    logic [7:0]  mask;
    mask = 8'h00;
    ones = 16'h0000;
    if (hsize <= 3'd3) begin
      ones = (16'd1 << (16'd1 << hsize)) - 16'd1;
      mask = 8'(ones << addr_lsbs);
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_mem_slave
//  Purpose  : AHB-Lite byte-addressed memory slave with fixed plus injected
//             wait states, strobe-aware lane writes and a two-cycle ERROR
//             response for out-of-range, misaligned, oversize or injected
//             faults.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int          MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          DATA_W      = 32,
  parameter int          WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [31:0]         HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic                HREADYIN,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic [3:0]          wait_inj,
  input  logic                err_inj,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                HREADYOUT,
  output logic [1:0]          HRESP
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_WAIT = 3'd1;
  localparam logic [2:0] c_DONE = 3'd2;
  localparam logic [2:0] c_ERR1 = 3'd3;
  localparam logic [2:0] c_ERR2 = 3'd4;

  logic [7:0]    mem [MEM_DEPTH];

  logic [2:0]    r_state;
  logic [4:0]    r_cnt;
  logic          r_write;
  logic [AW-1:0] r_base;
  logic [NB-1:0] r_mask;

  logic          w_accept;
  logic [32:0]   w_off;
  logic [7:0]    w_bytes;
  logic          w_range_err;
  logic          w_misalign;
  logic          w_too_big;
  logic          w_err;
  logic [4:0]    w_wait;

  // Address-phase decode: acceptance, offset into the array and fault checks.
  // The 33-bit subtraction puts addresses below the base into the borrow bit,
  // so one upper-bits test covers both ends of the window.
  always_comb begin
    w_accept    = HSEL && HREADYIN &&
                  (HTRANS == TRANS_NONSEQ || HTRANS == TRANS_SEQ);
    w_off       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    w_range_err = (w_off[32:AW] != '0);
    w_bytes     = 8'd1 << HSIZE;
    w_misalign  = (({5'd0, HADDR[2:0]} & (w_bytes - 8'd1)) != 8'd0);
    w_too_big   = (w_bytes > 8'(NB));
    w_err       = w_range_err || w_misalign || w_too_big || err_inj;
    w_wait      = 5'(WAIT_STATES) + {1'b0, wait_inj};
  end

  // Data-phase sequencer: accepts a new transfer from IDLE, DONE or ERR2.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_base  <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        c_WAIT: begin
          if (r_cnt == 5'd1) begin
            r_state <= c_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        c_ERR1: r_state <= c_ERR2;
        default: begin
          if (w_accept) begin
            r_write <= HWRITE;
            r_base  <= w_off[AW-1:0] & ~AW'(NB - 1);
            r_mask  <= NB'(size_mask(HSIZE, HADDR[2:0] & 3'(NB - 1)));
            if (w_err) begin
              r_state <= c_ERR1;
              r_cnt   <= '0;
            end else if (w_wait != 5'd0) begin
              r_state <= c_WAIT;
              r_cnt   <= w_wait;
            end else begin
              r_state <= c_DONE;
              r_cnt   <= '0;
            end
          end else begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Lane writes land at the end of the DONE cycle, when HWDATA is stable.
  always_ff @(posedge HCLK) begin
    if (!HRESET && r_state == c_DONE && r_write) begin
      for (int i = 0; i < NB; i++) begin
        if (r_mask[i] && WSTRB[i]) begin
          mem[r_base | AW'(i)] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Response and read data: full aligned word during a read DONE, else zero.
  always_comb begin
    HREADYOUT = !(r_state == c_WAIT || r_state == c_ERR1);
    HRESP     = (r_state == c_ERR1 || r_state == c_ERR2) ? ERROR : OKAY;
    HRDATA    = '0;
    if (r_state == c_DONE && !r_write) begin
      for (int i = 0; i < NB; i++) begin
        HRDATA[8*i +: 8] = mem[r_base | AW'(i)];
      end
    end
  end

endmodule
`default_nettype wire
